gpio_apb_arbiter: RTL and testbench

- Round-robin APB master arbiter sharing the single APB slave port of the grgpio_wrp GPIO block between NREQ on-chip requesters (CPU bridge, DMA, test sequencer).
- Each requester issues simple word read/write commands through a valid/ready handshake.
- The arbiter drives the apbi_* signals (APB2: no pready, fixed two-phase transfer) and returns read data with a one-cycle response pulse.

---
 rtl/gpio_apb_arbiter_if.sv | 42 ++++
 rtl/gpio_apb_arbiter.sv | 145 ++++++++++++++
 tb/tb_gpio_apb_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/gpio_apb_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the grgpio_wrp APB port.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the commands and answers the APB reads.
// GPIO_ARB_LOCK_EN adds the per-requester req_lock bits.
interface gpio_apb_arbiter_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ-1:0]      req_write;
   logic [NREQ*8-1:0]    req_addr;
   logic [NREQ*32-1:0]   req_wdata;
`ifdef GPIO_ARB_LOCK_EN
   logic [NREQ-1:0]      req_lock;
`endif
   logic [NREQ-1:0]      rsp_valid;
   logic [31:0]          rsp_rdata;
   logic                 apbi_psel;
   logic                 apbi_penable;
   logic [31:0]          apbi_paddr;
   logic                 apbi_pwrite;
   logic [31:0]          apbi_pwdata;
   logic [31:0]          apbo_prdata;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, apbo_prdata,
      output req_ready, rsp_valid, rsp_rdata,
      output apbi_psel, apbi_penable, apbi_paddr, apbi_pwrite, apbi_pwdata
`ifdef GPIO_ARB_LOCK_EN
      , input req_lock
`endif
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, apbo_prdata,
      input  req_ready, rsp_valid, rsp_rdata,
      input  apbi_psel, apbi_penable, apbi_paddr, apbi_pwrite, apbi_pwdata
`ifdef GPIO_ARB_LOCK_EN
      , output req_lock
`endif
   );
endinterface

// File: rtl/gpio_apb_arbiter.sv
// Round-robin arbiter sharing the grgpio_wrp APB2 slave port between NREQ
// requesters. One command is accepted in IDLE, then a fixed SETUP/ACCESS
// transfer runs and a one-hot rsp_valid pulse follows.
// Optional macro GPIO_ARB_LOCK_EN: a requester accepted with req_lock set keeps
// exclusive ownership of the arbiter until it issues an unlocked command.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | bus idle, arbitrate and accept one command
// SETUP  | APB setup phase, psel=1 penable=0
// ACCESS | APB access phase, psel=1 penable=1, capture read data
module gpio_apb_arbiter #(
   parameter int          NREQ      = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input logic               clk,
   input logic               rst,
   gpio_apb_arbiter_if.slave bus
);
   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t            state, state_nxt;
   logic [IDXW-1:0]   last_grant;
   logic [IDXW-1:0]   win_idx;
   logic [IDXW-1:0]   cand;
   logic              win_found;
   logic              accept;
   logic [NREQ-1:0]   eligible;
   logic [NREQ-1:0]   win_onehot;
   logic [NREQ-1:0]   grant_onehot;
   logic              cmd_write;
   logic [7:0]        cmd_addr;
   logic [31:0]       cmd_wdata;
   logic              cmd_lock;
   logic              lock_active;

   // Restrict competition to the lock owner while a locked sequence is open.
   always_comb begin
      eligible = bus.req_valid;
      if (lock_active) begin
         eligible             = '0;
         eligible[last_grant] = bus.req_valid[last_grant];
      end
   end

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDXW'((int'(last_grant) + k) % NREQ);
         if (!win_found && eligible[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Select the winner's command fields and build one-hot grant vectors.
   always_comb begin
      cmd_write  = 1'b0;
      cmd_addr   = '0;
      cmd_wdata  = '0;
      cmd_lock   = 1'b0;
      win_onehot = '0;
      grant_onehot = '0;
      win_onehot[win_idx]      = 1'b1;
      grant_onehot[last_grant] = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == IDXW'(i)) begin
            cmd_write = bus.req_write[i];
            cmd_addr  = bus.req_addr[i*8 +: 8];
            cmd_wdata = bus.req_wdata[i*32 +: 32];
`ifdef GPIO_ARB_LOCK_EN
            cmd_lock  = bus.req_lock[i];
`endif
         end
      end
   end

   // Next-state logic plus the handshake and APB phase strobes.
   always_comb begin
      state_nxt        = state;
      accept           = 1'b0;
      bus.req_ready    = '0;
      bus.apbi_psel    = 1'b0;
      bus.apbi_penable = 1'b0;
      case (state)
         IDLE: begin
            if (win_found) begin
               accept        = 1'b1;
               bus.req_ready = win_onehot;
               state_nxt     = SETUP;
            end
         end
         SETUP: begin
            bus.apbi_psel = 1'b1;
            state_nxt     = ACCESS;
         end
         ACCESS: begin
            bus.apbi_psel    = 1'b1;
            bus.apbi_penable = 1'b1;
            state_nxt        = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Latch the accepted command; APB address/data hold their value when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant      <= IDXW'(NREQ - 1);
         lock_active     <= 1'b0;
         bus.apbi_paddr  <= '0;
         bus.apbi_pwrite <= 1'b0;
         bus.apbi_pwdata <= '0;
      end else if (accept) begin
         last_grant      <= win_idx;
         lock_active     <= cmd_lock;
         bus.apbi_paddr  <= BASE_ADDR | {24'h0, cmd_addr[7:2], 2'b00};
         bus.apbi_pwrite <= cmd_write;
         bus.apbi_pwdata <= cmd_wdata;
      end
   end

   // Completion pulse to the owner and capture of read data at end of ACCESS.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rsp_valid <= '0;
         bus.rsp_rdata <= '0;
      end else begin
         bus.rsp_valid <= (state == ACCESS) ? grant_onehot : '0;
         if (state == ACCESS && !bus.apbi_pwrite) bus.rsp_rdata <= bus.apbo_prdata;
      end
   end
endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Directed bench for gpio_apb_arbiter with two requesters.
module tb_gpio_apb_arbiter;
   localparam int          NREQ = 2;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   gpio_apb_arbiter_if #(.NREQ(NREQ)) bus();

   gpio_apb_arbiter #(.NREQ(NREQ), .BASE_ADDR(BASE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.req_valid   = '0;
      bus.req_write   = '0;
      bus.req_addr    = '0;
      bus.req_wdata   = '0;
`ifdef GPIO_ARB_LOCK_EN
      bus.req_lock    = '0;
`endif
   endtask

   // Single transfer from requester r, starting at a negedge in IDLE.
   task automatic do_xfer(input string t, input int r, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_paddr,
                          input logic [31:0] exp_rdata);
      logic [NREQ-1:0] oh;
      oh = '0;
      oh[r] = 1'b1;
      bus.req_valid            = oh;
      bus.req_write[r]         = wr;
      bus.req_addr[r*8 +: 8]   = addr;
      bus.req_wdata[r*32 +: 32] = wd;
      #1 check({t, "_ready"}, 32'(bus.req_ready), 32'(oh));
      @(negedge clk);
      bus.req_valid = '0;
      check({t, "_setup_psel"},    32'(bus.apbi_psel), 32'd1);
      check({t, "_setup_penable"}, 32'(bus.apbi_penable), 32'd0);
      check({t, "_setup_paddr"},   bus.apbi_paddr, exp_paddr);
      check({t, "_setup_pwrite"},  32'(bus.apbi_pwrite), 32'(wr));
      check({t, "_setup_pwdata"},  bus.apbi_pwdata, wd);
      check({t, "_setup_ready"},   32'(bus.req_ready), 32'd0);
      @(negedge clk);
      check({t, "_access_psel"},    32'(bus.apbi_psel), 32'd1);
      check({t, "_access_penable"}, 32'(bus.apbi_penable), 32'd1);
      check({t, "_access_paddr"},   bus.apbi_paddr, exp_paddr);
      check({t, "_access_rsp"},     32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      check({t, "_rsp_valid"},   32'(bus.rsp_valid), 32'(oh));
      check({t, "_rsp_rdata"},   bus.rsp_rdata, exp_rdata);
      check({t, "_idle_psel"},   32'(bus.apbi_psel), 32'd0);
      check({t, "_idle_penable"}, 32'(bus.apbi_penable), 32'd0);
      check({t, "_idle_paddr"},  bus.apbi_paddr, exp_paddr);
   endtask

   initial begin
      logic [1:0] exp_rdy;
      logic [1:0] exp_rsp;
      idle_inputs();
      bus.apbo_prdata = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);

      check("rst_psel",    32'(bus.apbi_psel), 32'd0);
      check("rst_penable", 32'(bus.apbi_penable), 32'd0);
      check("rst_pwrite",  32'(bus.apbi_pwrite), 32'd0);
      check("rst_paddr",   bus.apbi_paddr, 32'd0);
      check("rst_pwdata",  bus.apbi_pwdata, 32'd0);
      check("rst_rdata",   bus.rsp_rdata, 32'd0);
      check("rst_rsp",     32'(bus.rsp_valid), 32'd0);
      check("rst_ready",   32'(bus.req_ready), 32'd0);
      rst = 1'b0;

      bus.apbo_prdata = 32'hDEAD_BEEF;
      do_xfer("wr0", 0, 1'b1, 8'h04, 32'h0000_00A5, BASE | 32'h04, 32'h0);
      bus.apbo_prdata = 32'h0000_005A;
      do_xfer("rd1", 1, 1'b0, 8'h00, 32'h0, BASE, 32'h0000_005A);
      bus.apbo_prdata = 32'hFFFF_0000;
      do_xfer("wr1", 1, 1'b1, 8'h08, 32'h0000_1234, BASE | 32'h08, 32'h0000_005A);
      do_xfer("a07", 0, 1'b1, 8'h07, 32'h0000_0077, BASE | 32'h04, 32'h0000_005A);

      // Both requesters continuously valid from reset.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = 2'b11;
      bus.req_write = 2'b11;
      for (int c = 0; c < 12; c++) begin
         exp_rdy = (c % 3 != 0) ? 2'b00 : (((c / 3) % 2 == 1) ? 2'b10 : 2'b01);
         exp_rsp = (c < 3 || c % 3 != 0) ? 2'b00 : ((((c / 3) - 1) % 2 == 1) ? 2'b10 : 2'b01);
         #1;
         check($sformatf("rr_ready_c%0d", c), 32'(bus.req_ready), 32'(exp_rdy));
         check($sformatf("rr_rsp_c%0d", c), 32'(bus.rsp_valid), 32'(exp_rsp));
         check($sformatf("rr_onehot_c%0d", c), 32'(bus.req_ready & (bus.req_ready - 2'd1)), 32'd0);
         @(negedge clk);
      end

      // Reset during SETUP aborts the transfer and restores requester 0 priority.
      bus.req_valid = 2'b01;
      #1 check("rstmid_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      check("rstmid_setup", 32'(bus.apbi_psel), 32'd1);
      bus.req_valid = 2'b00;
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_psel",    32'(bus.apbi_psel), 32'd0);
      check("rstmid_penable", 32'(bus.apbi_penable), 32'd0);
      check("rstmid_rsp0",    32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      check("rstmid_rsp1",    32'(bus.rsp_valid), 32'd0);
      check("rstmid_psel1",   32'(bus.apbi_psel), 32'd0);
      rst = 1'b0;
      bus.req_valid = 2'b11;
      #1 check("rstmid_first", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      bus.req_valid = 2'b00;
      repeat (2) @(negedge clk);

`ifdef GPIO_ARB_LOCK_EN
      // Locked read then unlocked write from req0 while req1 waits: 0,0,1.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      bus.req_valid = 2'b11;
      bus.req_lock  = 2'b01;
      bus.req_write = 2'b10;
      #1 check("lock_g0", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      bus.req_lock  = 2'b00;
      bus.req_write = 2'b11;
      repeat (2) @(negedge clk);
      #1 check("lock_g1", 32'(bus.req_ready), 32'd1);
      repeat (3) @(negedge clk);
      #1 check("lock_g2", 32'(bus.req_ready), 32'd2);
      @(negedge clk);
      idle_inputs();
      repeat (2) @(negedge clk);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
